// File: rtl/axis_uart_rx_buf.sv
// rtl/axis_uart_rx_buf.sv - UART receiver packing characters into buffered AXI-Stream words
module axis_uart_rx_buf #(
    parameter int AXI_DATA_WIDTH = 16,
    parameter int CLOCK          = 100_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_MODE    = 0,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_BITS   = 16
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  uart_rx,
    output logic [AXI_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [AXI_DATA_WIDTH/DATA_BITS-1:0]   m_axis_tkeep,
    output logic [2:0]                            m_axis_tuser,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  rx_parity_err,
    output logic                                  rx_frame_err,
    output logic                                  rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_count
);
    localparam int BYTES     = AXI_DATA_WIDTH / DATA_BITS;
    localparam int CS        = CLOCK / BAUD_RATE;
    localparam int HALF      = CS / 2;
    localparam int CW        = $clog2(CS);
    localparam int BW        = $clog2(DATA_BITS);
    localparam int LW        = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int FW        = AXI_DATA_WIDTH + BYTES + 3;
    localparam bit TMO_EN    = (TIMEOUT_BITS != 0) && (BYTES > 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CS;
    localparam int TW        = (TMO_LIMIT > 1) ? $clog2(TMO_LIMIT) : 1;
    localparam int TMO_LAST  = TMO_EN ? TMO_LIMIT - 1 : 0;
    localparam bit ODD       = (PARITY_MODE == 2);

    localparam logic [CW-1:0] C_S0  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1  = CW'(HALF);
    localparam logic [CW-1:0] C_S2  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_DEC = CW'(HALF + 2);
    localparam logic [CW-1:0] C_END = CW'(CS - 1);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_n;
    logic                    rx_meta, rxs, rxs_d;
    logic [CW-1:0]           cnt;
    logic [2:0]              samp;
    logic [BW-1:0]           bit_idx;
    logic                    stop_idx;
    logic [DATA_BITS-1:0]    shreg;
    logic                    par_flag;
    logic                    start_edge, at_dec, at_end, maj, exp_par;
    logic                    char_done, frame_bad, par_bad;
    logic [LW-1:0]           lane_cnt;
    logic [AXI_DATA_WIDTH-1:0] word_reg, word_nxt;
    logic [BYTES-1:0]        keep_part;
    logic                    acc_par, acc_frame;
    logic [TW-1:0]           tmo_cnt;
    logic                    tmo_fire;
    logic                    push_req;
    logic [FW-1:0]           push_word;
    logic [FW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic                    full, pop, push_ok;

    assign start_edge = rxs_d & ~rxs;
    assign at_dec     = (cnt == C_DEC);
    assign at_end     = (cnt == C_END);
    assign maj        = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign exp_par    = (^shreg) ^ ODD;

    // Two-flop synchronizer idling high, plus a delayed copy for falling-edge detect
    always_ff @(posedge aclk) begin
        if (areset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Receive state register
    always_ff @(posedge aclk) begin
        if (areset) state <= ARM;
        else        state <= state_n;
    end

    // Next state and per-character decision strobes
    always_comb begin
        state_n   = state;
        char_done = 1'b0;
        frame_bad = 1'b0;
        par_bad   = 1'b0;
        case (state)
            ARM:    if (rxs) state_n = IDLE;
            IDLE:   if (start_edge) state_n = START;
            START: begin
                if (at_dec && maj) state_n = IDLE;
                else if (at_end)   state_n = DATA;
            end
            DATA: begin
                if (at_end && bit_idx == BW'(DATA_BITS - 1))
                    state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (at_dec && (maj != exp_par)) par_bad = 1'b1;
                if (at_end) state_n = STOP;
            end
            STOP: begin
                if (at_dec) begin
                    if (stop_idx) begin
                        char_done = 1'b1;
                        state_n   = IDLE;
                    end else if (!maj) begin
                        char_done = 1'b1;
                        frame_bad = 1'b1;
                        state_n   = ARM;
                    end else if (STOP_BITS == 1) begin
                        char_done = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = ARM;
        endcase
    end

    // Baud counter, majority samples, data shifter and error pulses
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt           <= '0;
            samp          <= 3'b111;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            shreg         <= '0;
            par_flag      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            if (state == IDLE || state == ARM) cnt <= '0;
            else                               cnt <= at_end ? '0 : cnt + CW'(1);
            if (cnt == C_S0) samp[0] <= rxs;
            if (cnt == C_S1) samp[1] <= rxs;
            if (cnt == C_S2) samp[2] <= rxs;
            if (state != DATA)  bit_idx <= '0;
            else if (at_end)    bit_idx <= bit_idx + BW'(1);
            if (state != STOP)  stop_idx <= 1'b0;
            else if (at_end)    stop_idx <= 1'b1;
            if (state == DATA && at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state == START) par_flag <= 1'b0;
            else if (par_bad)   par_flag <= 1'b1;
            rx_parity_err <= par_bad;
            rx_frame_err  <= frame_bad;
        end
    end

    // Current word with the new character dropped into its lane, and the filled-lane mask
    always_comb begin
        word_nxt  = word_reg;
        keep_part = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (LW'(i) == lane_cnt) word_nxt[i*DATA_BITS +: DATA_BITS] = shreg;
            if (LW'(i) <  lane_cnt) keep_part[i] = 1'b1;
        end
    end

    assign tmo_fire = TMO_EN && (state == IDLE) && !start_edge &&
                      (lane_cnt != '0) && (tmo_cnt == TW'(TMO_LAST));

    // Idle timer for partial words; only advances while waiting for the next start bit
    always_ff @(posedge aclk) begin
        if (areset || !TMO_EN || tmo_fire || lane_cnt == '0 || state == START)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Word assembly; a full word or a timed-out partial word becomes a FIFO push next cycle
    always_ff @(posedge aclk) begin
        if (areset) begin
            lane_cnt  <= '0;
            word_reg  <= '0;
            acc_par   <= 1'b0;
            acc_frame <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            push_req <= 1'b0;
            if (char_done) begin
                if (lane_cnt == LW'(BYTES - 1)) begin
                    push_req  <= 1'b1;
                    push_word <= {word_nxt, {BYTES{1'b1}}, 1'b0,
                                  acc_frame | frame_bad, acc_par | par_flag};
                    lane_cnt  <= '0;
                    word_reg  <= '0;
                    acc_par   <= 1'b0;
                    acc_frame <= 1'b0;
                end else begin
                    word_reg  <= word_nxt;
                    lane_cnt  <= lane_cnt + LW'(1);
                    acc_par   <= acc_par | par_flag;
                    acc_frame <= acc_frame | frame_bad;
                end
            end else if (tmo_fire) begin
                push_req  <= 1'b1;
                push_word <= {word_reg, keep_part, 1'b1, acc_frame, acc_par};
                lane_cnt  <= '0;
                word_reg  <= '0;
                acc_par   <= 1'b0;
                acc_frame <= 1'b0;
            end
        end
    end

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = m_axis_tvalid & m_axis_tready;
    assign push_ok = push_req & (~full | pop);

    // FIFO storage, left unreset because the head is masked while empty
    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count      <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            rx_overrun <= push_req & full & ~pop;
        end
    end

    assign m_axis_tvalid = (count != '0);
    assign fifo_count    = count;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser} = m_axis_tvalid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_axis_uart_rx_buf.sv
// tb/tb_axis_uart_rx_buf.sv - directed self-checking bench for axis_uart_rx_buf
module tb_axis_uart_rx_buf;
    localparam int BIT = 100;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        m_axis_tready = 1'b1;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tkeep;
    logic [2:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        rx_parity_err, rx_frame_err, rx_overrun;
    logic [2:0]  fifo_count;

    axis_uart_rx_buf #(
        .AXI_DATA_WIDTH(16), .CLOCK(100_000_000), .BAUD_RATE(1_000_000),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(1), .FIFO_DEPTH(4), .TIMEOUT_BITS(20)
    ) dut (
        .aclk(aclk), .areset(areset), .uart_rx(uart_rx),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .fifo_count(fifo_count)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_err = 0;
    int par_n = 0;
    int frm_n = 0;
    int ovr_n = 0;
    int beat_n = 0;
    logic [20:0] beat_d [64];

    // Record pulses and transferred beats away from the active edge
    always @(negedge aclk) begin
        if (!areset) begin
            if (rx_parity_err) par_n <= par_n + 1;
            if (rx_frame_err)  frm_n <= frm_n + 1;
            if (rx_overrun)    ovr_n <= ovr_n + 1;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_d[beat_n[5:0]] <= {m_axis_tdata, m_axis_tkeep, m_axis_tuser};
                beat_n <= beat_n + 1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_char(input logic [7:0] d, input logic bad_par);
        uart_rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(BIT);
        end
        uart_rx = (^d) ^ bad_par;
        tick(BIT);
        uart_rx = 1'b1;
        tick(BIT);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int c = 0;
        while (beat_n < target && c < budget) begin
            tick(1);
            c++;
        end
        check({tag, "_arrive"}, 32'(beat_n >= target), 1);
    endtask

    task automatic check_beat(input string tag, input int k, input logic [15:0] data,
                              input logic [1:0] keep, input logic [2:0] user);
        logic [20:0] b;
        b = beat_d[k[5:0]];
        check({tag, "_tdata"}, 32'(b[20:5]), 32'(data));
        check({tag, "_tkeep"}, 32'(b[4:3]), 32'(keep));
        check({tag, "_tuser"}, 32'(b[2:0]), 32'(user));
    endtask

    initial begin
        int b0, p0, f0, o0;
        logic [7:0] lo, hi;

        tick(5);
        areset = 1'b0;
        tick(1);
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tdata", 32'(m_axis_tdata), 0);
        check("rst_tkeep", 32'(m_axis_tkeep), 0);
        check("rst_tuser", 32'(m_axis_tuser), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_pulses", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 0);
        tick(20);

        // Two clean characters form one full word
        b0 = beat_n; p0 = par_n; f0 = frm_n;
        send_char(8'h34, 1'b0);
        send_char(8'h12, 1'b0);
        wait_beats("t1", b0 + 1, 300);
        check_beat("t1", b0, 16'h1234, 2'b11, 3'b000);
        check("t1_par_pulses", 32'(par_n - p0), 0);
        check("t1_frm_pulses", 32'(frm_n - f0), 0);

        // Bad parity on the first character tags the word
        b0 = beat_n; p0 = par_n;
        send_char(8'hA5, 1'b1);
        send_char(8'h00, 1'b0);
        wait_beats("t2", b0 + 1, 300);
        check_beat("t2", b0, 16'h00A5, 2'b11, 3'b001);
        check("t2_par_pulses", 32'(par_n - p0), 1);

        // A short low glitch is rejected
        b0 = beat_n; p0 = par_n; f0 = frm_n;
        uart_rx = 1'b0;
        tick(30);
        uart_rx = 1'b1;
        tick(300);
        check("t3_no_beat", 32'(beat_n - b0), 0);
        check("t3_tvalid", 32'(m_axis_tvalid), 0);
        check("t3_pulses", 32'((par_n - p0) + (frm_n - f0)), 0);
        send_char(8'h0F, 1'b0);
        send_char(8'hF0, 1'b0);
        wait_beats("t3b", b0 + 1, 300);
        check_beat("t3b", b0, 16'hF00F, 2'b11, 3'b000);

        // Backpressure: four words buffered, the fifth dropped
        m_axis_tready = 1'b0;
        b0 = beat_n; o0 = ovr_n;
        for (int i = 0; i < 5; i++) begin
            lo = 8'hA0 + 8'(i);
            hi = 8'h50 + 8'(i);
            send_char(lo, 1'b0);
            send_char(hi, 1'b0);
            if (i == 3) begin
                tick(10);
                check("t4_no_early_ovr", 32'(ovr_n - o0), 0);
            end
        end
        tick(10);
        check("t4_fifo_full", 32'(fifo_count), 4);
        check("t4_overrun", 32'(ovr_n - o0), 1);
        check("t4_head", 32'(m_axis_tdata), 32'h50A0);
        check("t4_held", 32'(beat_n - b0), 0);
        m_axis_tready = 1'b1;
        wait_beats("t4", b0 + 4, 50);
        for (int i = 0; i < 4; i++) begin
            lo = 8'hA0 + 8'(i);
            hi = 8'h50 + 8'(i);
            check_beat($sformatf("t4_w%0d", i), b0 + i, {hi, lo}, 2'b11, 3'b000);
        end
        tick(200);
        check("t4_no_fifth", 32'(beat_n - b0), 4);
        check("t4_drained", 32'(fifo_count), 0);

        // Idle timeout flushes a lone character
        b0 = beat_n;
        send_char(8'h7E, 1'b0);
        wait_beats("t5", b0 + 1, 2500);
        check_beat("t5", b0, 16'h007E, 2'b01, 3'b100);

        // A start just before the timeout keeps the word together
        b0 = beat_n;
        send_char(8'h7E, 1'b0);
        tick(19 * BIT);
        send_char(8'h81, 1'b0);
        wait_beats("t5b", b0 + 1, 300);
        check_beat("t5b", b0, 16'h817E, 2'b11, 3'b000);

        // Break: one frame error, then the broken character is flushed
        b0 = beat_n; f0 = frm_n;
        uart_rx = 1'b0;
        tick(33 * BIT);
        check("t6_frame_once", 32'(frm_n - f0), 1);
        check("t6_no_beat", 32'(beat_n - b0), 0);
        uart_rx = 1'b1;
        wait_beats("t6", b0 + 1, 2600);
        check_beat("t6", b0, 16'h0000, 2'b01, 3'b110);
        b0 = beat_n;
        send_char(8'h55, 1'b0);
        send_char(8'hAA, 1'b0);
        wait_beats("t6b", b0 + 1, 300);
        check_beat("t6b", b0, 16'hAA55, 2'b11, 3'b000);

        // Reset mid-character discards buffered words
        m_axis_tready = 1'b0;
        b0 = beat_n;
        send_char(8'h11, 1'b0);
        send_char(8'h22, 1'b0);
        tick(5);
        check("t7_buffered", 32'(fifo_count), 1);
        uart_rx = 1'b0;
        tick(BIT);
        uart_rx = 1'b1;
        tick(BIT);
        uart_rx = 1'b0;
        tick(BIT / 2);
        areset = 1'b1;
        tick(1);
        check("t7_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("t7_rst_count", 32'(fifo_count), 0);
        areset = 1'b0;
        uart_rx = 1'b1;
        tick(12 * BIT);
        m_axis_tready = 1'b1;
        tick(5);
        check("t7_discarded", 32'(beat_n - b0), 0);
        send_char(8'h3C, 1'b0);
        send_char(8'hC3, 1'b0);
        wait_beats("t7", b0 + 1, 300);
        check_beat("t7", b0, 16'hC33C, 2'b11, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
